// File: rtl/zrl_scan_sequencer.sv
// Sequential scan-select: latches one block's transformer candidates and picks the longest zero-row run.
// Optional ZRL_EARLY_EXIT_EN ends the scan on the first candidate whose 16 rows are all zero.
module zrl_scan_sequencer #(
  parameter int NUM_PATTERNS          = 8,
  parameter int NUM_FIRST_TRANSFORMER = 2,
  parameter int NUM_LAST_TRANSFORMER  = 6,
  parameter int ZRL_THRESHOLD         = 1,
  localparam int NT         = NUM_LAST_TRANSFORMER - NUM_FIRST_TRANSFORMER + 1,
  localparam int LEN_ENCODE = $clog2(NUM_PATTERNS),
  localparam int IDX_W      = $clog2(NT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  isAllZero_i,
  input  logic                  isAllWordSame_i,
  input  logic [256*NT-1:0]     scanned_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LEN_ENCODE-1:0] select_o,
  output logic [255:0]          sel_scanned_o,
  output logic [4:0]            max_zrl_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state;
  logic [256*NT-1:0]  cand_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic [4:0]         best_q;

  logic [255:0]       cur;
  logic [255:0]       win;
  logic [4:0]         zrl;
  logic               run;
  logic               better;
  logic [4:0]         nbest;
  logic [IDX_W-1:0]   nidx;
  logic               finish;

  // Candidate i sits at slice NT-1-i so that the first transformer occupies the MSBs.
  function automatic logic [255:0] slice_of(input logic [256*NT-1:0] v, input logic [IDX_W-1:0] i);
    if (int'(i) < NT) return v[256*(NT-1-int'(i)) +: 256];
    return '0;
  endfunction

  always_comb begin
    cur = slice_of(cand_q, idx_q);
    zrl = '0;
    run = 1'b1;
    for (int unsigned r = 0; r < 16; r++) begin
      if (run && cur[255-16*r -: 16] == 16'h0000) zrl = zrl + 5'd1;
      else run = 1'b0;
    end
    // Strict compare keeps the lower index on ties.
    better = zrl > best_q;
    nbest  = better ? zrl : best_q;
    nidx   = better ? idx_q : best_idx_q;
    win    = slice_of(cand_q, nidx);
`ifdef ZRL_EARLY_EXIT_EN
    finish = (idx_q == IDX_W'(NT-1)) || (zrl == 5'd16);
`else
    finish = (idx_q == IDX_W'(NT-1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cand_q        <= '0;
      idx_q         <= '0;
      best_idx_q    <= '0;
      best_q        <= '0;
      in_ready_o    <= 1'b0;
      out_valid_o   <= 1'b0;
      select_o      <= '0;
      sel_scanned_o <= '0;
      max_zrl_o     <= '0;
      busy_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_o <= 1'b1;
          if (in_valid_i && in_ready_o) begin
            cand_q     <= scanned_i;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            if (isAllZero_i) begin
              state         <= DONE;
              out_valid_o   <= 1'b1;
              select_o      <= '0;
              sel_scanned_o <= '0;
              max_zrl_o     <= 5'd16;
            end else if (isAllWordSame_i) begin
              state         <= DONE;
              out_valid_o   <= 1'b1;
              select_o      <= LEN_ENCODE'(1);
              sel_scanned_o <= '0;
              max_zrl_o     <= '0;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          idx_q      <= idx_q + IDX_W'(1);
          best_q     <= nbest;
          best_idx_q <= nidx;
          if (finish) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
            max_zrl_o   <= nbest;
            if (int'(nbest) < ZRL_THRESHOLD) begin
              select_o      <= LEN_ENCODE'(NUM_PATTERNS-1);
              sel_scanned_o <= '0;
            end else begin
              select_o      <= LEN_ENCODE'(NUM_FIRST_TRANSFORMER + int'(nidx));
              sel_scanned_o <= win;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zrl_scan_sequencer.sv
// Directed self-checking bench for zrl_scan_sequencer with default parameters (NT = 5).
module tb_zrl_scan_sequencer;

  localparam int NT = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic             isAllZero_i = 1'b0;
  logic             isAllWordSame_i = 1'b0;
  logic [256*NT-1:0] scanned_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [2:0]       select_o;
  logic [255:0]     sel_scanned_o;
  logic [4:0]       max_zrl_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  zrl_scan_sequencer #(
    .NUM_PATTERNS(8),
    .NUM_FIRST_TRANSFORMER(2),
    .NUM_LAST_TRANSFORMER(6),
    .ZRL_THRESHOLD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .isAllZero_i(isAllZero_i), .isAllWordSame_i(isAllWordSame_i),
    .scanned_i(scanned_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .select_o(select_o), .sel_scanned_o(sel_scanned_o),
    .max_zrl_o(max_zrl_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Candidate with exactly k leading zero rows (row 0 = bits [255:240]); remaining rows nonzero.
  function automatic logic [255:0] mk(input int k, input logic [15:0] fill);
    logic [255:0] v;
    for (int r = 0; r < 16; r++) v[255-16*r -: 16] = (r < k) ? 16'h0000 : (fill | 16'h0001);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one block and returns once the accept edge has passed.
  task automatic send(input logic az, input logic aws, input logic [256*NT-1:0] data);
    int n = 0;
    while (!in_ready_o && n < 20) begin tick(); n++; end
    in_valid_i = 1'b1; isAllZero_i = az; isAllWordSame_i = aws; scanned_i = data;
    tick();
    in_valid_i = 1'b0; isAllZero_i = 1'b0; isAllWordSame_i = 1'b0;
    scanned_i = {NT{256'hDEAD_BEEF}};
  endtask

  // Latency counted from the accept edge: 1 means valid right after it.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid_o && lat < 40) begin tick(); lat++; end
  endtask

  task automatic handshake();
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; tick(); tick();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid_o); end
    checks++; if (select_o !== 3'd0) begin errors++; $display("FAIL reset_select got %0d exp 0", select_o); end
    checks++; if (sel_scanned_o !== 256'd0) begin errors++; $display("FAIL reset_scanned got %h exp 0", sel_scanned_o); end
    checks++; if (max_zrl_o !== 5'd0) begin errors++; $display("FAIL reset_max got %0d exp 0", max_zrl_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_o); end
  endtask

  task automatic test_bypass_zero();
    int lat;
    send(1'b1, 1'b1, {mk(3,16'h1111), mk(4,16'h2222), mk(5,16'h3333), mk(6,16'h4444), mk(7,16'h5555)});
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d exp 1", lat); end
    checks++; if (select_o !== 3'd0) begin errors++; $display("FAIL zero_select got %0d exp 0", select_o); end
    checks++; if (sel_scanned_o !== 256'd0) begin errors++; $display("FAIL zero_scanned got %h exp 0", sel_scanned_o); end
    checks++; if (max_zrl_o !== 5'd16) begin errors++; $display("FAIL zero_max got %0d exp 16", max_zrl_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL zero_busy got %0b exp 1", busy_o); end
    handshake();
  endtask

  task automatic test_bypass_same();
    int lat;
    send(1'b0, 1'b1, {mk(9,16'h1111), mk(4,16'h2222), mk(5,16'h3333), mk(6,16'h4444), mk(7,16'h5555)});
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL same_latency got %0d exp 1", lat); end
    checks++; if (select_o !== 3'd1) begin errors++; $display("FAIL same_select got %0d exp 1", select_o); end
    checks++; if (max_zrl_o !== 5'd0) begin errors++; $display("FAIL same_max got %0d exp 0", max_zrl_o); end
    checks++; if (sel_scanned_o !== 256'd0) begin errors++; $display("FAIL same_scanned got %h exp 0", sel_scanned_o); end
    handshake();
  endtask

  task automatic test_scan_tie();
    int lat;
    logic [255:0] c3;
    c3 = mk(7, 16'hB00B);
    send(1'b0, 1'b0, {mk(3,16'hA0A0), c3, mk(7,16'hC0C0), mk(2,16'hD0D0), mk(0,16'hE0E0)});
    wait_valid(lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL tie_latency got %0d exp 6", lat); end
    checks++; if (select_o !== 3'd3) begin errors++; $display("FAIL tie_select got %0d exp 3", select_o); end
    checks++; if (sel_scanned_o !== c3) begin errors++; $display("FAIL tie_scanned got %h exp %h", sel_scanned_o, c3); end
    checks++; if (max_zrl_o !== 5'd7) begin errors++; $display("FAIL tie_max got %0d exp 7", max_zrl_o); end
    handshake();
  endtask

  task automatic test_uncompressible();
    int lat;
    send(1'b0, 1'b0, {mk(0,16'h0101), mk(0,16'h0202), mk(0,16'h0303), mk(0,16'h0404), mk(0,16'h0505)});
    wait_valid(lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL unc_latency got %0d exp 6", lat); end
    checks++; if (select_o !== 3'd7) begin errors++; $display("FAIL unc_select got %0d exp 7", select_o); end
    checks++; if (sel_scanned_o !== 256'd0) begin errors++; $display("FAIL unc_scanned got %h exp 0", sel_scanned_o); end
    checks++; if (max_zrl_o !== 5'd0) begin errors++; $display("FAIL unc_max got %0d exp 0", max_zrl_o); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [255:0] c6;
    c6 = mk(12, 16'h7E57);
    send(1'b0, 1'b0, {mk(1,16'h1010), mk(11,16'h2020), mk(4,16'h3030), mk(0,16'h4040), c6});
    wait_valid(lat);
    // A competing block offered while DONE must be ignored.
    in_valid_i = 1'b1; isAllZero_i = 1'b1; scanned_i = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid_o !== 1'b1 || select_o !== 3'd6 || max_zrl_o !== 5'd12 || sel_scanned_o !== c6)
        begin errors++; $display("FAIL hold_outputs cyc %0d got v=%0b sel=%0d max=%0d exp v=1 sel=6 max=12", i, out_valid_o, select_o, max_zrl_o); end
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready got %0b exp 0", in_ready_o); end
    end
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    in_valid_i = 1'b0; isAllZero_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL hs_valid got %0b exp 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL hs_ready got %0b exp 1", in_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL hs_busy got %0b exp 0", busy_o); end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    send(1'b0, 1'b0, {mk(2,16'h1212), mk(5,16'h3434), mk(1,16'h5656), mk(3,16'h7878), mk(4,16'h9A9A)});
    tick(); tick();
    rst_n = 1'b0; #1;
    checks++; if (busy_o !== 1'b0 || select_o !== 3'd0 || max_zrl_o !== 5'd0 || in_ready_o !== 1'b0)
      begin errors++; $display("FAIL abort_reset got busy=%0b sel=%0d max=%0d rdy=%0b exp all 0", busy_o, select_o, max_zrl_o, in_ready_o); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (out_valid_o) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_novalid got %0d pulses exp 0", seen); end
    checks++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle got rdy=%0b busy=%0b exp 1 0", in_ready_o, busy_o); end
  endtask

  task automatic test_full_zero_candidate();
    int lat;
    int exp_lat;
`ifdef ZRL_EARLY_EXIT_EN
    exp_lat = 3;
`else
    exp_lat = 6;
`endif
    send(1'b0, 1'b0, {mk(3,16'h4141), mk(16,16'h0000), mk(5,16'h4343), mk(16,16'h0000), mk(1,16'h4545)});
    wait_valid(lat);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL full_latency got %0d exp %0d", lat, exp_lat); end
    checks++; if (select_o !== 3'd3) begin errors++; $display("FAIL full_select got %0d exp 3", select_o); end
    checks++; if (max_zrl_o !== 5'd16) begin errors++; $display("FAIL full_max got %0d exp 16", max_zrl_o); end
    checks++; if (sel_scanned_o !== 256'd0) begin errors++; $display("FAIL full_scanned got %h exp 0", sel_scanned_o); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_bypass_zero();
    test_bypass_same();
    test_scan_tie();
    test_uncompressible();
    test_backpressure();
    test_reset_abort();
    test_full_zero_candidate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zrl_scan_sequencer.md
Name: zrl_scan_sequencer

Overview:
- Time-multiplexed replacement for the fully parallel scan-select stage.
- Latches one block's transformer scan outputs and evaluates one candidate per cycle through a single shared zero-run-length unit.
- Tracks the maximum run, then presents the selected pattern code and scanned block to the downstream encoder with a valid/ready handshake.
- Sits between the transformer/scan stage and the pattern encoder in the compressor.

Parameters:
- NUM_PATTERNS, 8, number of pattern codes. Code 0 = all-zero, code 1 = all-word-same, code NUM_PATTERNS-1 = uncompressible.
- NUM_FIRST_TRANSFORMER, 2, pattern code of the first transformer candidate.
- NUM_LAST_TRANSFORMER, 6, pattern code of the last transformer candidate.
- ZRL_THRESHOLD, 1, minimum best run length (rows) needed to pick a transformer; below it the block is uncompressible.
- Derived: NT = NUM_LAST_TRANSFORMER-NUM_FIRST_TRANSFORMER+1; LEN_ENCODE = $clog2(NUM_PATTERNS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input block valid.
- in_ready_o  out  1  sequencer can accept a block.
- isAllZero_i  in  1  block is all zero.
- isAllWordSame_i  in  1  all words of the block are identical.
- scanned_i  in  256*NT  candidates. Code NUM_FIRST_TRANSFORMER occupies the MSB slice; each later code occupies the next 256 bits down.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- select_o  out  LEN_ENCODE  chosen pattern code.
- sel_scanned_o  out  256  chosen candidate, or 0 for codes 0, 1 and NUM_PATTERNS-1.
- max_zrl_o  out  5  winning zero-run length, 0..16.
- busy_o  out  1  high in SCAN or DONE.

Behaviour:
- Reset: state IDLE, all outputs 0, except in_ready_o = 1 after reset deasserts. All internal registers clear.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready_o = 1. Accept when in_valid_i is high; latch the flags and scanned_i.
  - isAllZero_i=1 -> DONE with select 0, max_zrl 16. isAllZero_i has priority over isAllWordSame_i.
  - Else isAllWordSame_i=1 -> DONE with select 1, max_zrl 0.
  - Else -> SCAN with idx=0, best=0, best_idx=0.
- SCAN:
  - Each cycle, evaluate candidate idx from the latched copy.
  - Split the candidate into 16 rows of 16 bits; row 0 is bits [255:240].
  - zrl = count of consecutive all-zero rows starting at row 0. Range 0..16; 16 means every row is zero.
  - Update best only if zrl > best (strict), so the lower index wins ties.
  - Leave SCAN after idx = NT-1 is evaluated. idx counter width is $clog2(NT+1).
- DONE:
  - Registered outputs valid; out_valid_o = 1.
  - If best < ZRL_THRESHOLD: select = NUM_PATTERNS-1 and sel_scanned = 0.
  - Otherwise: select = NUM_FIRST_TRANSFORMER + best_idx and sel_scanned = that candidate.
  - Outputs hold stable while out_ready_i = 0.
  - On handshake, go to IDLE and clear out_valid_o. in_ready_o rises the next cycle; there is no same-cycle back-to-back accept.
- Latency from the accept edge:
  - Bypass cases: out_valid_o after 1 cycle.
  - Scan case: after NT+1 cycles (NT evaluations, then DONE).
- Throughput: one block per NT+2 cycles at most.
- in_valid_i is ignored outside IDLE.
- scanned_i may change after the accept edge; it is never read again.
- rst_n asserted mid-SCAN or mid-DONE: immediate abort to reset values. The pending result is discarded and not emitted.

Optional Feature:
- Macro ZRL_EARLY_EXIT_EN.
- Defined: SCAN goes to DONE in the same cycle that any candidate yields zrl = 16. That candidate wins, as the first to reach the maximum; later candidates are skipped. Scan-case latency becomes (idx_of_hit+1)+1 cycles.
- Undefined: all NT candidates are always evaluated and latency is fixed. The selected code is identical either way.

Test Plan:
- Reset, then idle -> out_valid_o=0, select_o=0, sel_scanned_o=0, max_zrl_o=0, in_ready_o=1, busy_o=0.
- isAllZero_i=1 and isAllWordSame_i=1, accepted at cycle T -> out_valid_o=1 at T+1, select_o=0, sel_scanned_o=0, max_zrl_o=16.
- Defaults, flags 0, candidate ZRLs 3,7,7,2,0 (codes 2..6) -> out_valid_o at T+6, select_o=3, sel_scanned_o=code-3 slice, max_zrl_o=7.
- All candidates have row 0 nonzero -> select_o=7, sel_scanned_o=0, max_zrl_o=0.
- out_ready_i held low 4 cycles in DONE -> outputs stable, in_ready_o=0; after handshake, in_ready_o=1 one cycle later.
- rst_n pulsed low at the 3rd SCAN cycle -> no out_valid_o pulse, reset values restored. With ZRL_EARLY_EXIT_EN and the code-3 candidate all zero: select_o=3, max_zrl_o=16, out_valid_o at T+3.
